// File: rtl/subtractor_serial_pkg.sv
// Shared definitions for the digit-serial 16-bit subtractor.
// Holds the FSM state type and the digit-counter width helper.
package subtractor_serial_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that must hold 0 .. digits-1; never narrower than one bit.
    function automatic int cntWidth(input int digits);
        return (digits <= 1) ? 1 : $clog2(digits);
    endfunction

endpackage

// File: rtl/subtractor_digit.sv
// Combinational W-bit ripple subtractor with borrow-in and borrow-out.
// Computes i_a - i_b - i_bin one bit at a time, LSB first.
module subtractor_digit #(
    parameter int W = 4
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_bin,
    output logic [W-1:0] o_diff,
    output logic         o_bout
);

    logic [W:0] w_borrow;

    // Full-subtractor chain: each bit borrows when a < b + borrow-in.
    always_comb begin
        w_borrow    = '0;
        o_diff      = '0;
        w_borrow[0] = i_bin;
        for (int i = 0; i < W; i++) begin
            o_diff[i]       = i_a[i] ^ i_b[i] ^ w_borrow[i];
            w_borrow[i + 1] = (~i_a[i] & i_b[i]) | (~i_a[i] & w_borrow[i]) | (i_b[i] & w_borrow[i]);
        end
    end

    assign o_bout = w_borrow[W];

endmodule

// File: rtl/subtractor_serial_16b.sv
// Digit-serial 16-bit subtractor: diff = (in0 - in1 - bin) mod 2^16.
// One DIGIT_W-bit digit is processed per cycle, LSB digit first, with a
// valid/ready handshake on both the operand and result sides.
// Optional feature: define SUBTRACTOR_SERIAL_16B_OVF_EN to compile in
// two's-complement overflow detection on ovf; otherwise ovf is tied to 0.
module subtractor_serial_16b
    import subtractor_serial_pkg::*;
#(
    parameter int DIGIT_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_val,
    output logic        in_rdy,
    input  logic [15:0] in0,
    input  logic [15:0] in1,
    input  logic        bin,
    output logic        out_val,
    input  logic        out_rdy,
    output logic [15:0] diff,
    output logic        bout,
    output logic        ovf
);

    localparam int N     = (DIGIT_W > 0) ? (DATA_W / DIGIT_W) : 1;
    localparam int CNT_W = cntWidth(N);
    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // Only digit widths that tile the 16-bit word exactly are meaningful.
    generate
        if (DIGIT_W < 1 || DIGIT_W > DATA_W || (DATA_W % DIGIT_W) != 0) begin : g_badDigitW
            $error("subtractor_serial_16b: DIGIT_W must divide 16 (1, 2, 4, 8 or 16)");
        end
    endgenerate

    state_t             r_state;
    logic               r_inRdy;
    logic               r_outVal;
    logic [15:0]        r_opA;
    logic [15:0]        r_opB;
    logic               r_borrow;
    logic [CNT_W-1:0]   r_cnt;
    logic [15:0]        r_work;
    logic [15:0]        r_diff;
    logic               r_bout;

    logic [3:0]         w_base;
    logic [DIGIT_W-1:0] w_digA;
    logic [DIGIT_W-1:0] w_digB;
    logic [DIGIT_W-1:0] w_digDiff;
    logic               w_digBout;
    logic [15:0]        w_merged;

    assign w_base = 4'(int'(r_cnt) * DIGIT_W);
    assign w_digA = r_opA[w_base +: DIGIT_W];
    assign w_digB = r_opB[w_base +: DIGIT_W];

    subtractor_digit #(
        .W (DIGIT_W)
    ) u_digit (
        .i_a    (w_digA),
        .i_b    (w_digB),
        .i_bin  (r_borrow),
        .o_diff (w_digDiff),
        .o_bout (w_digBout)
    );

    // Partial result with the digit being computed this cycle dropped into place.
    always_comb begin
        w_merged = r_work;
        w_merged[w_base +: DIGIT_W] = w_digDiff;
    end

    // Handshake FSM plus serial datapath; outputs only change at acceptance end-of-CALC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_inRdy  <= 1'b0;
            r_outVal <= 1'b0;
            r_opA    <= '0;
            r_opB    <= '0;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
            r_work   <= '0;
            r_diff   <= '0;
            r_bout   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_inRdy <= 1'b1;
                    if (in_val && r_inRdy) begin
                        r_opA    <= in0;
                        r_opB    <= in1;
                        r_borrow <= bin;
                        r_cnt    <= '0;
                        r_work   <= '0;
                        r_inRdy  <= 1'b0;
                        r_state  <= CALC;
                    end
                end
                CALC: begin
                    r_work   <= w_merged;
                    r_borrow <= w_digBout;
                    r_cnt    <= r_cnt + CNT_ONE;
                    if (r_cnt == LAST_DIGIT) begin
                        r_diff   <= w_merged;
                        r_bout   <= w_digBout;
                        r_outVal <= 1'b1;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    if (out_rdy) begin
                        r_outVal <= 1'b0;
                        r_inRdy  <= 1'b1;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    r_inRdy  <= 1'b0;
                    r_outVal <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

`ifdef SUBTRACTOR_SERIAL_16B_OVF_EN
    logic r_ovf;

    // Signed overflow: operand signs differ and the result sign departs from the minuend.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (r_state == CALC && r_cnt == LAST_DIGIT) begin
            r_ovf <= (r_opA[15] != r_opB[15]) && (w_merged[15] != r_opA[15]);
        end
    end

    assign ovf = r_ovf;
`else
    assign ovf = 1'b0;
`endif

    assign in_rdy  = r_inRdy;
    assign out_val = r_outVal;
    assign diff    = r_diff;
    assign bout    = r_bout;

endmodule
